decoder_seq_onehot: RTL and testbench

Parametrised, registered binary-to-one-hot decoder. It extends the combinational 2-to-4 and 3-to-8 decoders to N inputs and 2^N outputs. Besides direct decode it has an auto-scan mode and a single-sweep mode, so one block can drive chip-select, LED-column or channel-enable lines either from a supplied index or as a free-running or one-shot sequencer. It sits between the control logic and whatever one-hot-selected resources the design has.

---
 rtl/decoder_seq_onehot.sv | 159 +++++++++++++++
 tb/tb_decoder_seq_onehot.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq_onehot.sv
// Registered binary-to-one-hot decoder with direct, scan and sweep modes.
// One-hot select for chip-select, LED-column or channel-enable lines.
module decoder_seq_onehot #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  input  logic [N-1:0]      x_i,
  input  logic              load_i,
  output logic [2**N-1:0]   y_o,
  output logic [N-1:0]      idx_o,
  output logic              wrap_o,
  output logic              done_o
);

  localparam int M  = 2**N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};
  localparam logic [M-1:0]  ONE      = M'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN,
    S_SWEEP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  y_q, y_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  logic          last_dwell;
  logic          at_top;
  logic [N-1:0]  idx_inc;
  logic [M-1:0]  y_x;
  logic [M-1:0]  y_inc;

  assign last_dwell = (cnt_q == CNT_LAST);
  assign at_top     = (idx_q == IDX_LAST);
  assign idx_inc    = idx_q + 1'b1;
  assign y_x        = ONE << x_i;
  assign y_inc      = ONE << idx_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    done_d  = done_q;

    if (en_i) begin
      unique case (mode_i)
        2'b00: begin
          state_d = S_IDLE;
          y_d     = '0;
          done_d  = 1'b0;
        end

        2'b01: begin
          state_d = S_DIRECT;
          idx_d   = x_i;
          y_d     = y_x;
          done_d  = 1'b0;
        end

        2'b10: begin
          done_d = 1'b0;
          if (state_q != S_SCAN) begin
            state_d = S_SCAN;
            idx_d   = '0;
            y_d     = ONE;
            cnt_d   = '0;
          end else if (load_i) begin
            idx_d = x_i;
            y_d   = y_x;
            cnt_d = '0;
          end else if (last_dwell) begin
            idx_d  = idx_inc;
            y_d    = y_inc;
            cnt_d  = '0;
            wrap_d = at_top;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        2'b11: begin
          if (state_q == S_DONE) begin
            y_d    = '0;
            done_d = 1'b1;
          end else if (state_q != S_SWEEP) begin
            state_d = S_SWEEP;
            idx_d   = '0;
            y_d     = ONE;
            cnt_d   = '0;
            done_d  = 1'b0;
          end else if (load_i) begin
            idx_d = x_i;
            y_d   = y_x;
            cnt_d = '0;
          end else if (last_dwell) begin
            cnt_d = '0;
            // Last index finished its dwell: park with idx held.
            if (at_top) begin
              state_d = S_DONE;
              y_d     = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_inc;
              y_d   = y_inc;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
          y_d     = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign y_o    = y_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_decoder_seq_onehot.sv
// Bench for decoder_seq_onehot: vector table, corner sequences
// and randomized traffic against a position-based reference model.
module tb_decoder_seq_onehot;

  localparam int N     = 3;
  localparam int DWELL = 2;
  localparam int M     = 8;

  localparam int P_IDLE = 0;
  localparam int P_DIR  = 1;
  localparam int P_SCAN = 2;
  localparam int P_SWP  = 3;
  localparam int P_DONE = 4;

  logic         clk = 1'b0;
  logic         rst, en, load;
  logic [1:0]   mode;
  logic [N-1:0] x;
  logic [M-1:0] y;
  logic [N-1:0] idx;
  logic         wrap, done;

  int errors = 0;
  int checks = 0;

  int           ph, base, t;
  logic [M-1:0] my;
  logic [N-1:0] midx;
  logic         mwrap, mdone;

  always #5 clk = ~clk;

  decoder_seq_onehot #(.N(N), .DWELL(DWELL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en),
    .mode_i(mode),
    .x_i   (x),
    .load_i(load),
    .y_o   (y),
    .idx_o (idx),
    .wrap_o(wrap),
    .done_o(done)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] x;
    logic       load;
    logic [7:0] ey;
    logic [2:0] eidx;
    logic       ewrap;
    logic       edone;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model position: scanned index = base + enabled cycles / DWELL.
  task automatic model_edge();
    int p;
    if (rst) begin
      ph = P_IDLE; my = '0; midx = '0;
      mwrap = 0; mdone = 0; t = 0; base = 0;
    end else if (!en) begin
      mwrap = 0;
    end else begin
      mwrap = 0;
      case (mode)
        2'd0: begin ph = P_IDLE; my = '0; mdone = 0; end
        2'd1: begin
          ph = P_DIR; midx = x; my = M'(1) << x; mdone = 0;
        end
        2'd2: begin
          mdone = 0;
          if (ph != P_SCAN) begin
            ph = P_SCAN; base = 0; t = 0;
          end else if (load) begin
            base = int'(x); t = 0;
          end else begin
            t++;
            p = base + t / DWELL;
            mwrap = (t % DWELL == 0) && (p % M == 0);
          end
          p = (base + t / DWELL) % M;
          midx = p[N-1:0];
          my = M'(1) << p;
        end
        default: begin
          if (ph == P_DONE) begin
            // parked
          end else if (ph != P_SWP) begin
            ph = P_SWP; base = 0; t = 0;
            midx = '0; my = M'(1); mdone = 0;
          end else begin
            if (load) begin
              base = int'(x); t = 0;
            end else begin
              t++;
            end
            p = base + t / DWELL;
            if (p >= M) begin
              ph = P_DONE; my = '0; mdone = 1;
            end else begin
              midx = p[N-1:0]; my = M'(1) << p;
            end
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("y_model", 32'(y), 32'(my));
    chk("idx_model", 32'(idx), 32'(midx));
    chk("wrap_model", 32'(wrap), 32'(mwrap));
    chk("done_model", 32'(done), 32'(mdone));
    chk("onehot", 32'($countones(y) <= 1), 32'd1);
  endtask

  task automatic drive(logic r, logic e, logic [1:0] m,
                       logic [N-1:0] xv, logic l);
    rst = r; en = e; mode = m; x = xv; load = l;
  endtask

  vec_t vt[9];
  int   wraps;

  initial begin
    drive(1, 1, 2'd2, 0, 0);
    ph = P_IDLE; base = 0; t = 0;
    my = '0; midx = '0; mwrap = 0; mdone = 0;

    vt[0] = '{1, 1, 2'd2, 3'd0, 0, 8'h00, 3'd0, 0, 0};
    vt[1] = '{1, 1, 2'd2, 3'd0, 0, 8'h00, 3'd0, 0, 0};
    vt[2] = '{0, 1, 2'd2, 3'd0, 0, 8'h01, 3'd0, 0, 0};
    vt[3] = '{0, 1, 2'd2, 3'd0, 0, 8'h01, 3'd0, 0, 0};
    vt[4] = '{0, 1, 2'd2, 3'd0, 0, 8'h02, 3'd1, 0, 0};
    vt[5] = '{0, 1, 2'd1, 3'd5, 0, 8'h20, 3'd5, 0, 0};
    vt[6] = '{0, 0, 2'd1, 3'd2, 0, 8'h20, 3'd5, 0, 0};
    vt[7] = '{0, 1, 2'd1, 3'd2, 1, 8'h04, 3'd2, 0, 0};
    vt[8] = '{0, 1, 2'd0, 3'd7, 0, 8'h00, 3'd2, 0, 0};

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].x, vt[i].load);
      tick();
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vt[i].ey));
      chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(vt[i].eidx));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vt[i].ewrap));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].edone));
    end

    // Continuous scan over a full period plus a little
    drive(0, 1, 2'd2, 0, 0);
    wraps = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("scan_y", 32'(y), 32'(1) << (((e - 1) / DWELL) % M));
      chk("scan_wrap", 32'(wrap), 32'(e == 17));
      wraps += int'(wrap);
    end
    chk("scan_wrap_count", 32'(wraps), 32'd1);

    // One-shot sweep then park
    drive(0, 1, 2'd0, 0, 0);
    tick();
    drive(0, 1, 2'd3, 0, 0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("sweep_y", 32'(y),
          (e <= 16) ? (32'(1) << ((e - 1) / DWELL)) : 32'd0);
      chk("sweep_done", 32'(done), 32'(e > 16));
      chk("sweep_wrap", 32'(wrap), 32'd0);
    end
    drive(0, 1, 2'd0, 0, 0);
    tick();
    chk("done_clear", 32'(done), 32'd0);

    // Load in scan at idx 3, then load on final dwell of idx 7
    drive(0, 1, 2'd2, 0, 0);
    for (int e = 1; e <= 7; e++) tick();
    chk("pre_load_idx", 32'(idx), 32'd3);
    drive(0, 1, 2'd2, 3'd6, 1);
    tick();
    chk("load6_y", 32'(y), 32'h40);
    drive(0, 1, 2'd2, 3'd0, 0);
    tick();
    chk("load6_hold", 32'(y), 32'h40);
    tick();
    chk("load6_adv", 32'(y), 32'h80);
    tick();
    chk("idx7_dwell", 32'(idx), 32'd7);
    drive(0, 1, 2'd2, 3'd1, 1);
    tick();
    chk("loadwrap_y", 32'(y), 32'h02);
    chk("loadwrap_nowrap", 32'(wrap), 32'd0);
    drive(0, 1, 2'd2, 3'd0, 0);
    tick();
    chk("loadwrap_hold", 32'(y), 32'h02);

    // Reset mid-scan at idx 5
    drive(0, 1, 2'd0, 0, 0);
    tick();
    drive(0, 1, 2'd2, 0, 0);
    for (int e = 1; e <= 11; e++) tick();
    chk("pre_rst_idx", 32'(idx), 32'd5);
    drive(1, 1, 2'd2, 0, 0);
    tick();
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    drive(0, 1, 2'd2, 0, 0);
    tick();
    chk("restart_y", 32'(y), 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 11) == 0);
      x    = N'($urandom_range(0, M - 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
